i2c_mem_slave: RTL and testbench



---
 rtl/i2c_mem_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_mem_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_slave.sv
// ---------------------------------------------------------------------------
// i2c_mem_slave
//
// I2C responder that plays the EEPROM side of the eeprom_top master link.
// It holds a 128 x 8 memory. Each transaction carries a 7-bit address, an
// R/W bit (1 = write, 0 = read) and one data byte. SDA is open-drain: this
// block only ever pulls it low or releases it.
//
// Parameters
//   SYNC_STAGES   synchronizer depth on scl_i and sda_io (must be >= 2)
//
// Ports
//   clk_i         system clock, same domain as the master
//   rst_n_i       asynchronous active-low reset
//   scl_i         I2C clock from the master (input only)
//   sda_io        open-drain data line (drives 1'b0 or 1'bz)
//   busy_o        high from a detected START until STOP or return to IDLE
//   wr_strobe_o   one-cycle pulse when a write byte is committed to memory
//   last_addr_o   memory address of the most recent transaction
//   last_data_o   byte most recently written or read out
// ---------------------------------------------------------------------------
module i2c_mem_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic       busy_o,
    output logic       wr_strobe_o,
    output logic [6:0] last_addr_o,
    output logic [7:0] last_data_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WDATA,
        ACK_D,
        RDATA,
        MACK,
        WAIT_STOP
    } state_t;

    // Synchronizers and edge-detect flops
    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;

    logic sclS;
    logic sdaS;
    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;

    // Protocol state
    state_t      state_q,    state_d;
    logic [3:0]  bitCnt_q,   bitCnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        rw_q,       rw_d;
    logic        sdaOe_q,    sdaOe_d;
    logic        busy_q,     busy_d;
    logic        wrStrobe_q, wrStrobe_d;
    logic [6:0]  lastAddr_q, lastAddr_d;
    logic [7:0]  lastData_q, lastData_d;

    logic        memWe;
    logic [7:0]  memWdata;
    logic [2:0]  rdIdx;

    logic [7:0]  mem [128];

    // The synchronizers reset to 1 so that an idle bus after reset release
    // does not look like an SDA/SCL edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_io};
            sclPrev_q <= sclSync_q[SYNC_STAGES-1];
            sdaPrev_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclS     = sclSync_q[SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startDet = sdaPrev_q & ~sdaS & sclS;
    assign stopDet  = ~sdaPrev_q & sdaS & sclS;

    // Bit index presented during RDATA; bitCnt_q is 1..7 whenever it is used.
    assign rdIdx = 3'd7 - bitCnt_q[2:0];

    // Next-state logic. START/STOP are checked first so they override any
    // SCL edge seen in the same cycle. In ADDR and WDATA the counter reaches
    // 8 on the last sampled bit; the following SCL fall moves into the ACK
    // clock, so the ACK drive only ever changes while SCL is low.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sdaOe_d    = sdaOe_q;
        busy_d     = busy_q;
        wrStrobe_d = 1'b0;
        lastAddr_d = lastAddr_q;
        lastData_d = lastData_q;
        memWe      = 1'b0;
        memWdata   = 8'h00;

        if (startDet) begin
            state_d  = ADDR;
            bitCnt_d = 4'd0;
            shift_d  = 8'h00;
            sdaOe_d  = 1'b0;
            busy_d   = 1'b1;
        end else if (stopDet) begin
            state_d  = IDLE;
            bitCnt_d = 4'd0;
            sdaOe_d  = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d  = 1'b0;
                    sdaOe_d = 1'b0;
                end

                ADDR: begin
                    if (sclRise && bitCnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sdaS};
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            lastAddr_d = shift_q[6:0];
                            rw_d       = sdaS;
                        end
                    end else if (sclFall && bitCnt_q == 4'd8) begin
                        state_d  = ACK_A;
                        sdaOe_d  = 1'b1;
                        bitCnt_d = 4'd0;
                        if (!rw_q) begin
                            lastData_d = mem[lastAddr_q];
                        end
                    end
                end

                ACK_A: begin
                    if (sclFall) begin
                        if (rw_q) begin
                            state_d  = WDATA;
                            sdaOe_d  = 1'b0;
                            bitCnt_d = 4'd0;
                        end else begin
                            state_d  = RDATA;
                            sdaOe_d  = ~lastData_q[7];
                            bitCnt_d = 4'd1;
                        end
                    end
                end

                WDATA: begin
                    if (sclRise && bitCnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sdaS};
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            memWe      = 1'b1;
                            memWdata   = {shift_q[6:0], sdaS};
                            lastData_d = {shift_q[6:0], sdaS};
                            wrStrobe_d = 1'b1;
                        end
                    end else if (sclFall && bitCnt_q == 4'd8) begin
                        state_d  = ACK_D;
                        sdaOe_d  = 1'b1;
                        bitCnt_d = 4'd0;
                    end
                end

                ACK_D: begin
                    if (sclFall) begin
                        state_d = WAIT_STOP;
                        sdaOe_d = 1'b0;
                    end
                end

                RDATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            state_d  = MACK;
                            sdaOe_d  = 1'b0;
                            bitCnt_d = 4'd0;
                        end else begin
                            sdaOe_d  = ~lastData_q[rdIdx];
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                end

                MACK: begin
                    if (sclFall) begin
                        state_d = WAIT_STOP;
                        sdaOe_d = 1'b0;
                    end
                end

                WAIT_STOP: begin
                    sdaOe_d = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                    sdaOe_d = 1'b0;
                end
            endcase
        end
    end

    // State registers. The SDA enable is reset asynchronously so reset
    // releases the line without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            wrStrobe_q <= 1'b0;
            lastAddr_q <= 7'd0;
            lastData_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sdaOe_q    <= sdaOe_d;
            busy_q     <= busy_d;
            wrStrobe_q <= wrStrobe_d;
            lastAddr_q <= lastAddr_d;
            lastData_q <= lastData_d;
        end
    end

    // Memory array: deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem[lastAddr_q] <= memWdata;
        end
    end

    assign sda_io      = sdaOe_q ? 1'b0 : 1'bz;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wrStrobe_q;
    assign last_addr_o = lastAddr_q;
    assign last_data_o = lastData_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_mem_slave
//
// Self-checking bench for i2c_mem_slave. A bit-banged master drives SCL and
// an open-drain SDA with a pull-up. Expected write commits and read bytes are
// queued when a transaction is issued; separate monitor processes pop and
// compare them when the DUT pulses wr_strobe or when a read byte has been
// clocked in.
// ---------------------------------------------------------------------------
module tb_i2c_mem_slave;

    localparam int SYNC = 2;
    localparam int Q    = 10;

    logic       clk = 1'b0;
    logic       rstN;
    logic       scl;
    logic       mOe;
    wire        sda;
    logic       busy;
    logic       wrStrobe;
    logic [6:0] lastAddr;
    logic [7:0] lastData;

    int nAsserts = 0;
    int nFails   = 0;

    logic [14:0] expWrQ [$];
    logic [7:0]  expRdQ [$];
    logic [7:0]  rdByte;
    event        rdDone;

    assign sda = mOe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_mem_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .scl_i       (scl),
        .sda_io      (sda),
        .busy_o      (busy),
        .wr_strobe_o (wrStrobe),
        .last_addr_o (lastAddr),
        .last_data_o (lastData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: set SDA while SCL is low, sample it mid-high.
    task automatic clockBit(input logic b, output logic s);
        mOe = ~b;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        s = sda;
        waitClk(Q);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic startCond();
        mOe = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        mOe = 1'b1;
        waitClk(Q);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic stopCond();
        mOe = 1'b1;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        mOe = 1'b0;
        waitClk(Q);
    endtask

    task automatic sendByte(input logic [7:0] v, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(v[i], s);
        end
        clockBit(1'b1, s);
        checkOutput({name, " ack"}, {31'd0, s}, 32'd0);
    endtask

    task automatic readByte(output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            v[i] = s;
        end
        clockBit(1'b1, s);
    endtask

    // One complete transaction; the expected outcome is queued before the
    // bus activity so the monitors can check it when the DUT responds.
    task automatic applyStimulus(input logic isWrite, input logic [6:0] addr,
                                 input logic [7:0] data, input logic withStop);
        logic [7:0] v;
        startCond();
        checkOutput("busy after start", {31'd0, busy}, 32'd1);
        sendByte({addr, isWrite}, "addr");
        if (isWrite) begin
            expWrQ.push_back({addr, data});
            sendByte(data, "data");
        end else begin
            expRdQ.push_back(data);
            readByte(v);
            rdByte = v;
            ->rdDone;
        end
        if (withStop) begin
            stopCond();
            waitClk(SYNC + 4);
            checkOutput("busy after stop", {31'd0, busy}, 32'd0);
            checkOutput("last_addr", {25'd0, lastAddr}, {25'd0, addr});
            checkOutput("last_data", {24'd0, lastData}, {24'd0, data});
        end
    endtask

    // Write-commit monitor
    always @(negedge clk) begin
        logic [14:0] exp;
        if (wrStrobe === 1'b1) begin
            nAsserts++;
            if (expWrQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected wr_strobe: got addr 0x%0h data 0x%0h, expected no strobe",
                         lastAddr, lastData);
            end else begin
                exp = expWrQ.pop_front();
                if ({lastAddr, lastData} !== exp) begin
                    nFails++;
                    $display("[TB] FAIL write commit: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             lastAddr, lastData, exp[14:8], exp[7:0]);
                end
            end
        end
    end

    // Read-byte monitor
    initial begin
        logic [7:0] exp;
        forever begin
            @(rdDone);
            nAsserts++;
            if (expRdQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected read: got 0x%0h, expected nothing", rdByte);
            end else begin
                exp = expRdQ.pop_front();
                if (rdByte !== exp) begin
                    nFails++;
                    $display("[TB] FAIL read byte: got 0x%0h, expected 0x%0h", rdByte, exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic s;
        rstN = 1'b0;
        scl  = 1'b1;
        mOe  = 1'b0;
        waitClk(5);
        $display("[TB] reset values");
        checkOutput("reset sda", {31'd0, sda}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset wr_strobe", {31'd0, wrStrobe}, 32'd0);
        checkOutput("reset last_addr", {25'd0, lastAddr}, 32'd0);
        checkOutput("reset last_data", {24'd0, lastData}, 32'd0);
        rstN = 1'b1;
        waitClk(10);

        $display("[TB] write 0xA5 to 0x50, then read back");
        applyStimulus(1'b1, 7'h50, 8'hA5, 1'b1);
        applyStimulus(1'b0, 7'h50, 8'hA5, 1'b1);

        $display("[TB] repeated start: write 0x3C to 0x12, read 0x12");
        applyStimulus(1'b1, 7'h12, 8'h3C, 1'b0);
        applyStimulus(1'b0, 7'h12, 8'h3C, 1'b1);

        $display("[TB] abort a write of 0xFF to 0x50 after 4 bits");
        startCond();
        sendByte({7'h50, 1'b1}, "abort addr");
        for (int i = 0; i < 4; i++) begin
            clockBit(1'b1, s);
        end
        stopCond();
        waitClk(SYNC + 4);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort sda released", {31'd0, sda}, 32'd1);
        applyStimulus(1'b0, 7'h50, 8'hA5, 1'b1);

        $display("[TB] reset while driving a 0 data bit");
        startCond();
        sendByte({7'h50, 1'b0}, "mid-read addr");
        clockBit(1'b1, s);
        checkOutput("mid-read bit7", {31'd0, s}, 32'd1);
        mOe = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        checkOutput("mid-read bit6 driven", {31'd0, sda}, 32'd0);
        rstN = 1'b0;
        #1;
        checkOutput("reset releases sda", {31'd0, sda}, 32'd1);
        checkOutput("mid-read reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid-read reset wr_strobe", {31'd0, wrStrobe}, 32'd0);
        checkOutput("mid-read reset last_addr", {25'd0, lastAddr}, 32'd0);
        checkOutput("mid-read reset last_data", {24'd0, lastData}, 32'd0);
        waitClk(3);
        rstN = 1'b1;
        waitClk(Q);
        scl = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(2 * Q);
        applyStimulus(1'b1, 7'h7F, 8'h01, 1'b1);

        $display("[TB] edge addresses and data");
        applyStimulus(1'b1, 7'h00, 8'hFF, 1'b1);
        applyStimulus(1'b1, 7'h7F, 8'h00, 1'b1);
        applyStimulus(1'b0, 7'h00, 8'hFF, 1'b1);
        applyStimulus(1'b0, 7'h7F, 8'h00, 1'b1);
        applyStimulus(1'b1, 7'h00, 8'h00, 1'b1);
        applyStimulus(1'b1, 7'h7F, 8'hFF, 1'b1);
        applyStimulus(1'b0, 7'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 7'h7F, 8'hFF, 1'b1);

        waitClk(20);
        checkOutput("pending writes", expWrQ.size(), 32'd0);
        checkOutput("pending reads", expRdQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
